// File: rtl/rs232_pkg.sv
// ---------------------------------------------------------------------------
// rs232_pkg
//   Shared definitions for the RS232 UART polling masters (TX and RX).
//   - Avalon byte addresses of the UART core registers
//   - Status register bit positions
//   - TX master state encoding
//   - Helper that formats a byte as an Avalon write word
// ---------------------------------------------------------------------------
package rs232_pkg;

    // UART core register map (byte addresses)
    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    // Status register bits
    localparam int TX_OK_BIT = 6;   // TRDY: transmit holding register free
    localparam int RX_OK_BIT = 7;   // RRDY: receive data available

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POLL  = 3'd1,
        S_WRITE = 3'd2,
        S_CSUM  = 3'd3
    } tx_state_t;

    // The UART TX data register takes the byte in the low lane.
    function automatic logic [31:0] tx_word(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

endpackage

// File: rtl/rs232_tx_fifo.sv
// ---------------------------------------------------------------------------
// rs232_tx_fifo
//   Synchronous single-clock FIFO buffering bytes for the TX master.
//   Head word is read combinationally (first-word fall-through).
//   A push while full is honoured only when a pop happens in the same cycle;
//   the count then stays unchanged.
//
// Parameters
//   WIDTH   data width
//   DEPTH   number of entries, power of two >= 2
//
// Ports
//   i_clk     clock
//   i_rst     synchronous active-high reset, empties the FIFO
//   i_push    write i_wdata
//   i_wdata   data to write
//   i_pop     discard head entry
//   o_rdata   head entry (valid when !o_empty)
//   o_full    registered, high when count == DEPTH
//   o_empty   high when count == 0
//   o_count   number of stored entries
// ---------------------------------------------------------------------------
module rs232_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;

    logic [AW:0]      w_count_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // When full, the slot being written is the head being popped this cycle.
    assign w_do_push = i_push && (!r_full || w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/rs232_tx_master.sv
// ---------------------------------------------------------------------------
// rs232_tx_master
//   Avalon-MM master for the transmit side of the RS232 UART core. Bytes
//   arrive on a valid/ready stream, are buffered in a FIFO, and each one is
//   written to the TX data register after a STATUS poll reports TRDY.
//
// Build option
//   RS232_TX_CHECKSUM_EN : after every FRAME_LEN payload bytes written, an
//                          XOR checksum byte is written before any further
//                          payload byte. Undefined: plain byte pass-through.
//
// Parameters
//   FIFO_DEPTH   input buffer depth (power of two, >= 2)
//   FRAME_LEN    payload bytes per frame, 1..255 (checksum option only)
//
// Ports
//   avm_clk          clock
//   avm_rst          synchronous active-high reset
//   avm_address      byte address into UART core (TX=4, STATUS=8)
//   avm_read         read request
//   avm_readdata     read data, valid when read && !waitrequest
//   avm_write        write request
//   avm_writedata    {24'b0, byte} while writing, otherwise 0
//   avm_waitrequest  slave stall; request/address/data held while high
//   i_data           byte to transmit
//   i_valid          i_data valid
//   o_ready          FIFO not full
//   o_busy           FIFO non-empty, FSM active or checksum pending
//   o_dbg_state      current FSM state
//
// Stream handshake: a byte transfers on every rising edge where
// i_valid && o_ready. o_ready is registered and never depends on i_valid;
// i_data must be stable whenever i_valid is high.
// ---------------------------------------------------------------------------
module rs232_tx_master
    import rs232_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 64
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_busy,
    output tx_state_t   o_dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if (FRAME_LEN < 1 || FRAME_LEN > 255 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("rs232_tx_master: FIFO_DEPTH or FRAME_LEN out of range");
    end

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    w_fifo_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_valid && !w_fifo_full;

    rs232_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (avm_clk),
        .i_rst   (avm_rst),
        .i_push  (w_push),
        .i_wdata (i_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // ------------------------------------------------------ registered state
    tx_state_t   r_state;
    logic        r_read;
    logic        r_write;
    logic [4:0]  r_address;
    logic [31:0] r_writedata;
    // Data-available flag seen by S_IDLE. It is registered from the count and
    // forced low on the pop edge, so IDLE never acts on a count that is about
    // to drop; this also gives the push-to-write latency of four cycles.
    logic        r_have_data;

    tx_state_t   w_state_nxt;
    logic        w_read_nxt;
    logic        w_write_nxt;
    logic [4:0]  w_address_nxt;
    logic [31:0] w_writedata_nxt;
    logic        w_tx_ok;
    logic        w_frame_done;
    logic        w_unused_readdata;

    assign w_tx_ok           = avm_readdata[TX_OK_BIT];
    assign w_unused_readdata = ^{avm_readdata[31:TX_OK_BIT+1], avm_readdata[TX_OK_BIT-1:0]};

    // Payload pop happens exactly when the payload write is accepted.
    assign w_pop = (r_state == S_WRITE) && r_write && !avm_waitrequest;

`ifdef RS232_TX_CHECKSUM_EN
    localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);

    logic [7:0] r_csum_cnt;
    logic [7:0] r_csum_acc;
    logic       w_csum_done;

    assign w_frame_done = (r_csum_cnt == FRAME_LEN_B);
    assign w_csum_done  = (r_state == S_CSUM) && r_write && !avm_waitrequest;

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            r_csum_cnt <= 8'h00;
            r_csum_acc <= 8'h00;
        end else if (w_csum_done) begin
            r_csum_cnt <= 8'h00;
            r_csum_acc <= 8'h00;
        end else if (w_pop) begin
            r_csum_cnt <= r_csum_cnt + 8'h01;
            r_csum_acc <= r_csum_acc ^ r_writedata[7:0];
        end
    end
`else
    assign w_frame_done = 1'b0;
`endif

    // ------------------------------------------------------------ FSM: next
    always_comb begin
        w_state_nxt     = r_state;
        w_read_nxt      = r_read;
        w_write_nxt     = r_write;
        w_address_nxt   = r_address;
        w_writedata_nxt = r_writedata;

        case (r_state)
            S_IDLE: begin
                // A completed frame takes priority over further payload.
                if (w_frame_done || r_have_data) begin
                    w_state_nxt   = S_POLL;
                    w_read_nxt    = 1'b1;
                    w_address_nxt = STATUS_BASE;
                end
            end

            S_POLL: begin
                if (r_read) begin
                    if (!avm_waitrequest) begin
                        w_read_nxt = 1'b0;
                        if (w_tx_ok) begin
                            w_write_nxt   = 1'b1;
                            w_address_nxt = TX_BASE;
`ifdef RS232_TX_CHECKSUM_EN
                            if (w_frame_done) begin
                                w_state_nxt     = S_CSUM;
                                w_writedata_nxt = tx_word(r_csum_acc);
                            end else begin
                                w_state_nxt     = S_WRITE;
                                w_writedata_nxt = tx_word(w_fifo_head);
                            end
`else
                            w_state_nxt     = S_WRITE;
                            w_writedata_nxt = tx_word(w_fifo_head);
`endif
                        end
                    end
                end else begin
                    // Idle gap after a not-ready poll: issue the next read.
                    w_read_nxt    = 1'b1;
                    w_address_nxt = STATUS_BASE;
                end
            end

            S_WRITE, S_CSUM: begin
                if (r_write && !avm_waitrequest) begin
                    w_write_nxt     = 1'b0;
                    w_writedata_nxt = 32'h0000_0000;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_state_nxt     = S_IDLE;
                w_read_nxt      = 1'b0;
                w_write_nxt     = 1'b0;
                w_address_nxt   = STATUS_BASE;
                w_writedata_nxt = 32'h0000_0000;
            end
        endcase
    end

    // ------------------------------------------------------ FSM: registers
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            r_state     <= S_IDLE;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= STATUS_BASE;
            r_writedata <= 32'h0000_0000;
            r_have_data <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_read      <= w_read_nxt;
            r_write     <= w_write_nxt;
            r_address   <= w_address_nxt;
            r_writedata <= w_writedata_nxt;
            r_have_data <= (w_fifo_count != '0) && !w_pop;
        end
    end

    // ------------------------------------------------------------- outputs
    assign avm_address   = r_address;
    assign avm_read      = r_read;
    assign avm_write     = r_write;
    assign avm_writedata = r_writedata;
    assign o_ready       = !w_fifo_full;
    assign o_busy        = !w_fifo_empty || (r_state != S_IDLE) || w_frame_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rs232_tx_master.sv
module tb_rs232_tx_master;
    import rs232_pkg::*;

    localparam int DEPTH = 16;
    localparam int FRAME = 4;
`ifdef RS232_TX_CHECKSUM_EN
    localparam int CSUM_EN = 1;
`else
    localparam int CSUM_EN = 0;
`endif

    // ------------------------------------------------ clock / reset / DUT
    logic        clk = 1'b0;
    logic        avm_rst;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_busy;
    tx_state_t   dbg_state;

    always #5 clk = ~clk;

    rs232_tx_master #(
        .FIFO_DEPTH (DEPTH),
        .FRAME_LEN  (FRAME)
    ) dut (
        .avm_clk         (clk),
        .avm_rst         (avm_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .i_data          (i_data),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .o_busy          (o_busy),
        .o_dbg_state     (dbg_state)
    );

    // ------------------------------------------------------------ state
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  wr_log[$];
    int          cyc = 0;
    int          n_reads = 0;
    int          n_writes = 0;
    int          write_cyc = 0;
    int          acc_cyc = 0;
    logic        last_read_ok = 1'b0;
    int          wait_n = 0;
    int          polls_left = 0;
    logic        trdy_low = 1'b0;
    int          stall_cnt = 0;
    logic        prev_pend = 1'b0;
    logic [38:0] prev_bus = '0;
`ifdef RS232_TX_CHECKSUM_EN
    int          m_cnt = 0;
    logic [7:0]  m_acc = 8'h00;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------- UART slave model + scoreboard monitor
    always @(negedge clk) begin : mon
        logic [31:0] st;
        logic [7:0]  e;
        if (avm_read || avm_write) begin
            if (stall_cnt < wait_n) begin
                avm_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end else begin
            avm_waitrequest = 1'b0;
            stall_cnt = 0;
        end
        // Not-ready status has every other bit set to show they are ignored.
        st = (trdy_low || polls_left > 0) ? 32'hFFFF_FFBF : 32'h0000_0040;
        avm_readdata = avm_read ? st : 32'h0;

        if (avm_rst) begin
            prev_pend    = 1'b0;
            last_read_ok = 1'b0;
            stall_cnt    = 0;
        end else begin
            total++;
            if (avm_read && avm_write) begin
                bad++;
                $display("FAIL rd_wr_overlap: read=%0b write=%0b want not both", avm_read, avm_write);
            end
            if (!avm_write) begin
                total++;
                if (avm_writedata !== 32'h0) begin
                    bad++;
                    $display("FAIL writedata_idle: got %08h want 00000000", avm_writedata);
                end
            end
            if (prev_pend) begin
                total++;
                if ({avm_read, avm_write, avm_address, avm_writedata} !== prev_bus) begin
                    bad++;
                    $display("FAIL hold_on_wait: got %010h want %010h",
                             {avm_read, avm_write, avm_address, avm_writedata}, prev_bus);
                end
            end
            if (avm_read && !avm_waitrequest) begin
                n_reads++;
                total++;
                if (avm_address !== 5'd8) begin
                    bad++;
                    $display("FAIL read_addr: got %0d want 8", avm_address);
                end
                last_read_ok = st[6];
                if (polls_left > 0) polls_left--;
            end
            if (avm_write && !avm_waitrequest) begin
                n_writes++;
                write_cyc = cyc;
                wr_log.push_back(avm_writedata[7:0]);
                total++;
                if (!last_read_ok) begin
                    bad++;
                    $display("FAIL write_before_trdy: got last_status_ok=0 want 1");
                end
                last_read_ok = 1'b0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got data %08h want no write", avm_writedata);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (avm_address !== 5'd4 || avm_writedata !== {24'h0, e}) begin
                        bad++;
                        $display("FAIL write_data: got addr %0d data %08h want addr 4 data %08h",
                                 avm_address, avm_writedata, {24'h0, e});
                    end
                end
            end
            prev_pend = (avm_read || avm_write) && avm_waitrequest;
            prev_bus  = {avm_read, avm_write, avm_address, avm_writedata};
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Called just after a negedge; returns one cycle after acceptance with
    // i_valid still high so back-to-back calls stream without gaps.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        i_data  = b;
        i_valid = 1'b1;
        while (!o_ready && guard < 3000) begin
            tick();
            guard++;
        end
        total++;
        if (!o_ready) begin
            bad++;
            $display("FAIL push_timeout: got o_ready=0 want 1 for byte %02h", b);
            i_valid = 1'b0;
        end else begin
            exp_q.push_back(b);
            acc_cyc = cyc;
`ifdef RS232_TX_CHECKSUM_EN
            m_cnt++;
            m_acc = m_acc ^ b;
            if (m_cnt == FRAME) begin
                exp_q.push_back(m_acc);
                m_cnt = 0;
                m_acc = 8'h00;
            end
`endif
            tick();
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        wr_log.delete();
        polls_left = 0;
        trdy_low   = 1'b0;
        wait_n     = 0;
`ifdef RS232_TX_CHECKSUM_EN
        m_cnt = 0;
        m_acc = 8'h00;
`endif
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        avm_rst = 1'b1;
        repeat (3) tick();
        avm_rst = 1'b0;
        clear_model();
        tick();
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || o_busy) && guard < 5000) begin
            tick();
            guard++;
        end
        total++;
        if (exp_q.size() != 0 || o_busy) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending busy=%0b want 0 pending", exp_q.size(), o_busy);
        end
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        int g = 0;
        int w0;
        avm_rst = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (3) tick();
        total++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin bad++; $display("FAIL rst_req: got r=%0b w=%0b want 0 0", avm_read, avm_write); end
        total++; if (avm_address !== 5'd8) begin bad++; $display("FAIL rst_addr: got %0d want 8", avm_address); end
        total++; if (avm_writedata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %08h want 0", avm_writedata); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", o_ready); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", o_busy); end
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        avm_rst = 1'b0;
        clear_model();
        tick();

        // Reset while a write is stalled by the slave.
        wait_n = 8;
        send_byte(8'h5A);
        i_valid = 1'b0;
        while (!avm_write && g < 40) begin tick(); g++; end
        total++; if (avm_write !== 1'b1) begin bad++; $display("FAIL rst_setup: got write=%0b want 1", avm_write); end
        w0 = n_writes;
        avm_rst = 1'b1;
        repeat (3) tick();
        total++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin bad++; $display("FAIL midrst_req: got r=%0b w=%0b want 0 0", avm_read, avm_write); end
        total++; if (avm_address !== 5'd8) begin bad++; $display("FAIL midrst_addr: got %0d want 8", avm_address); end
        total++; if (avm_writedata !== 32'h0) begin bad++; $display("FAIL midrst_wdata: got %08h want 0", avm_writedata); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %0b want 1", o_ready); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0b want 0", o_busy); end
        avm_rst = 1'b0;
        clear_model();
        repeat (20) tick();
        total++; if (n_writes !== w0) begin bad++; $display("FAIL midrst_lost: got %0d writes want %0d", n_writes, w0); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midrst_idle: got busy=%0b want 0", o_busy); end
    endtask

    task automatic test_single();
        int r0, w0, k;
        int g = 0;
        do_reset();
        r0 = n_reads;
        w0 = n_writes;
        send_byte(8'hA5);
        i_valid = 1'b0;
        k = acc_cyc;
        while (n_writes == w0 && g < 30) begin tick(); g++; end
        total++; if (write_cyc !== k + 4) begin bad++; $display("FAIL latency: got cycle %0d want %0d", write_cyc, k + 4); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL busy_during_write: got %0b want 1", o_busy); end
        tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL busy_after_write: got %0b want 0", o_busy); end
        repeat (5) tick();
        total++; if (n_writes - w0 !== 1) begin bad++; $display("FAIL single_writes: got %0d want 1", n_writes - w0); end
        total++; if (n_reads - r0 !== 1) begin bad++; $display("FAIL single_reads: got %0d want 1", n_reads - r0); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL single_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_trdy_low();
        int r0, w0;
        do_reset();
        polls_left = 5;
        r0 = n_reads;
        w0 = n_writes;
        send_byte(8'h3C);
        i_valid = 1'b0;
        wait_drain();
        repeat (3) tick();
        total++; if (n_reads - r0 !== 6) begin bad++; $display("FAIL trdy_reads: got %0d want 6", n_reads - r0); end
        total++; if (n_writes - w0 !== 1) begin bad++; $display("FAIL trdy_writes: got %0d want 1", n_writes - w0); end
    endtask

    task automatic test_waitrequest();
        int r0, w0;
        do_reset();
        wait_n = 3;
        r0 = n_reads;
        w0 = n_writes;
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        i_valid = 1'b0;
        wait_drain();
        repeat (3) tick();
        total++; if (n_writes - w0 !== 16 + 4 * CSUM_EN) begin bad++; $display("FAIL wait_writes: got %0d want %0d", n_writes - w0, 16 + 4 * CSUM_EN); end
        total++; if (n_reads - r0 !== 16 + 4 * CSUM_EN) begin bad++; $display("FAIL wait_reads: got %0d want %0d", n_reads - r0, 16 + 4 * CSUM_EN); end
    endtask

    task automatic test_overflow();
        int w0;
        do_reset();
        trdy_low = 1'b1;
        w0 = n_writes;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h40 + 8'(i));
            if (i == 14) begin
                total++;
                if (o_ready !== 1'b1) begin bad++; $display("FAIL ready_at_15: got %0b want 1", o_ready); end
            end
        end
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL ready_at_16: got %0b want 0", o_ready); end
        i_data  = 8'h50;
        i_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (o_ready !== 1'b0) begin bad++; $display("FAIL ready_held_off: got %0b want 0", o_ready); end
        end
        total++; if (n_writes !== w0) begin bad++; $display("FAIL write_while_trdy_low: got %0d want %0d", n_writes, w0); end
        trdy_low = 1'b0;
        for (int i = 16; i < 20; i++) send_byte(8'h40 + 8'(i));
        i_valid = 1'b0;
        wait_drain();
        total++; if (n_writes - w0 !== 20 + 5 * CSUM_EN) begin bad++; $display("FAIL ovf_writes: got %0d want %0d", n_writes - w0, 20 + 5 * CSUM_EN); end
    endtask

    task automatic test_checksum();
        logic [7:0] pat [8];
        pat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'hFF, 8'h00, 8'hFF};
        do_reset();
        wait_n = $urandom_range(0, 2);
        foreach (pat[i]) send_byte(pat[i]);
        i_valid = 1'b0;
        wait_drain();
        repeat (3) tick();
        total++;
        if (wr_log.size() !== 8 + 2 * CSUM_EN) begin
            bad++;
            $display("FAIL csum_count: got %0d want %0d", wr_log.size(), 8 + 2 * CSUM_EN);
        end else begin
`ifdef RS232_TX_CHECKSUM_EN
            total++; if (wr_log[4] !== 8'h0F) begin bad++; $display("FAIL csum_frame1: got %02h want 0f", wr_log[4]); end
            total++; if (wr_log[9] !== 8'h00) begin bad++; $display("FAIL csum_frame2: got %02h want 00", wr_log[9]); end
            total++; if (wr_log[5] !== 8'h00) begin bad++; $display("FAIL csum_next_payload: got %02h want 00", wr_log[5]); end
`else
            total++; if (wr_log[4] !== 8'h00) begin bad++; $display("FAIL payload_5th: got %02h want 00", wr_log[4]); end
            total++; if (wr_log[7] !== 8'hFF) begin bad++; $display("FAIL payload_8th: got %02h want ff", wr_log[7]); end
`endif
        end
    endtask

    // ---------------------------------------------------------- sequence
    initial begin
        avm_rst = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        test_reset();
        test_single();
        test_trdy_low();
        test_waitrequest();
        test_overflow();
        test_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
